imem_refill_unit: RTL
=====================

IMEM_REFILL_UNIT -- requirements
Module: imem_refill_unit

Interface
REQ-001 Parameter LINE_WORDS, 4, words per I-cache line; power of two, at least 2.
REQ-002 Parameter ADDR_W, `pc_size, address width.
REQ-003 Parameter WORD_W, `memory_word, data word width.
REQ-004 One clock; reset is asynchronous and active-low (ports clk and nrst).
REQ-005 clk  in  1  clock; all state changes on its rising edge.
REQ-006 nrst  in  1  asynchronous active-low reset.
REQ-007 miss_cache  in  1  refill request from the fetch unit; level, held until the line is filled.
REQ-008 ram_address  in  ADDR_W  missing fetch address; sampled only on miss acceptance.
REQ-009 mem_word  out  WORD_W  refill word returned to the fetch unit.
REQ-010 word_ready  out  1  one-cycle pulse; mem_word valid in that cycle.
REQ-011 mem_req  out  1  read request to instruction RAM.
REQ-012 mem_addr  out  ADDR_W  word address of the current request.
REQ-013 mem_gnt  in  1  RAM accepts the request in a cycle where mem_req=1.
REQ-014 mem_rvalid  in  1  RAM read data valid; earliest one cycle after the grant.
REQ-015 mem_rdata  in  WORD_W  RAM read data.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, REQ, WAIT, DONE.
REQ-018 IDLE with miss_cache=1: latch base = ram_address with its low log2(LINE_WORDS*4) bits cleared; clear beat_cnt; go to REQ.
REQ-019 REQ: mem_req=1 and mem_addr=base+4*beat_cnt; both held stable until mem_gnt; on mem_gnt go to WAIT.
REQ-020 WAIT: mem_req=0; on mem_rvalid, register mem_rdata into mem_word and pulse word_ready in the next cycle.
REQ-021 WAIT with mem_rvalid: if beat_cnt==LINE_WORDS-1 go to DONE, else increment beat_cnt and go to REQ.
REQ-022 beat_cnt is log2(LINE_WORDS) bits wide; address arithmetic is modulo 2^ADDR_W; words are returned in ascending order from base.
REQ-023 DONE: stay until miss_cache=0, then go to IDLE; a stale miss never restarts a refill.
REQ-024 mem_word holds its last value between pulses; word_ready never asserts outside a delivered beat.
REQ-025 miss_cache falling in REQ before the grant: drop mem_req and go to IDLE immediately.
REQ-026 miss_cache falling in WAIT: wait for the outstanding mem_rvalid, discard it without a word_ready pulse, then go to IDLE.
REQ-027 mem_rvalid in IDLE, REQ or DONE is ignored.
REQ-028 Latency, zero-wait RAM (grant in the first REQ cycle, rvalid one cycle later): first word_ready 3 cycles after miss_cache rises; one word every 2 cycles after that.

Reset
REQ-029 nrst=0 forces, immediately and asynchronously: state IDLE, beat_cnt=0, base=0, mem_word=0, word_ready=0, mem_req=0, mem_addr=0, busy=0.
REQ-030 Reset during a burst abandons it; no word_ready is produced for any beat in flight.

Structure
REQ-031 The refill_state_t enum and the LINE_WORDS default live in the shared constants package.
REQ-032 Single module, no sub-modules; the FSM, beat counter and data register are inline.

Verification
REQ-033 Miss at 0x0000_0014, zero-wait RAM -> mem_addr 0x10, 0x14, 0x18, 0x1C in order; 4 word_ready pulses carrying matching mem_rdata; then DONE.
REQ-034 mem_gnt delayed 3 cycles on beat 2 -> mem_req and mem_addr=0x18 held stable for all 4 cycles; no extra word_ready.
REQ-035 miss_cache dropped in WAIT of beat 1 -> one pending rvalid discarded, no pulse, IDLE with mem_req=0.
REQ-036 nrst pulsed during beat 3 -> all outputs 0 in the same cycle; a new miss at 0x0000_0100 refills 0x100-0x10C correctly.
REQ-037 miss_cache held high for 5 cycles after the 4th word -> FSM stays in DONE, mem_req stays 0; next rise at 0xFFFF_FFF0 refills 0xFFFF_FFF0-0xFFFF_FFFC without wrap error.

Source files
------------

// File: rtl/imem_refill_unit_pkg.sv
// Shared constants and state type for the instruction-memory line refill unit.
package imem_refill_unit_pkg;

    localparam int LINE_WORDS_DEFAULT = 4;
    localparam int ADDR_W_DEFAULT     = 32;
    localparam int WORD_W_DEFAULT     = 32;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } refill_state_t;

endpackage

// File: rtl/imem_refill_unit.sv
// Refills one I-cache line from instruction RAM, one word per request/response
// handshake, handing each word to the fetch unit as a single-cycle pulse.
module imem_refill_unit
    import imem_refill_unit_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEFAULT,
    parameter int ADDR_W     = ADDR_W_DEFAULT,
    parameter int WORD_W     = WORD_W_DEFAULT
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              miss_cache,
    input  logic [ADDR_W-1:0] ram_address,
    output logic [WORD_W-1:0] mem_word,
    output logic              word_ready,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] OFFS_MASK = ADDR_W'(LINE_WORDS * 4 - 1);

    refill_state_t     state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              ready_q, ready_d;
    logic              abort_q, abort_d;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            base_q  <= '0;
            word_q  <= '0;
            ready_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
            word_q  <= word_d;
            ready_q <= ready_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        base_d  = base_q;
        word_d  = word_q;
        ready_d = 1'b0;
        abort_d = abort_q;

        unique case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (miss_cache) begin
                    base_d  = ram_address & ~OFFS_MASK;
                    beat_d  = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (!miss_cache) begin
                    state_d = IDLE;
                end else if (mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // An abandoned miss still owes the RAM its response; swallow it here.
                if (mem_rvalid) begin
                    abort_d = 1'b0;
                    if (!miss_cache || abort_q) begin
                        state_d = IDLE;
                    end else begin
                        word_d  = mem_rdata;
                        ready_d = 1'b1;
                        if (beat_q == LAST_BEAT) begin
                            state_d = DONE;
                        end else begin
                            beat_d  = beat_q + 1'b1;
                            state_d = REQ;
                        end
                    end
                end else if (!miss_cache) begin
                    abort_d = 1'b1;
                end
            end
            DONE: begin
                if (!miss_cache) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_req    = (state_q == REQ) && miss_cache;
    assign mem_addr   = base_q + ADDR_W'({beat_q, 2'b00});
    assign mem_word   = word_q;
    assign word_ready = ready_q;
    assign busy       = (state_q != IDLE);

endmodule
